uart_transmitter: RTL and testbench

//  Serialises bytes onto an 8-data-bit UART line (start, 8 data LSB-first, optional parity, 1-2 stop).

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_baud_gen.sv | 33 +++
 rtl/uart_transmitter.sv | 143 ++++++++++++++
 tb/tb_uart_transmitter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: state encoding,
// data width and the parity helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE       = 3'd0,
    TX_START_BIT  = 3'd1,
    TX_DATA_BITS  = 3'd2,
    TX_PARITY_BIT = 3'd3,
    TX_STOP_BITS  = 3'd4
  } tx_state_t;

  function automatic logic tx_parity(input logic [UART_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: free-runs 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. restart parks the counter at zero.
module uart_tx_baud_gen #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic restart,
  output logic bit_last,
  output logic bit_last_next
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt + CNT_W'(1);
    if (restart || bit_last) cnt_n = '0;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) cnt <= '0;
    else          cnt <= cnt_n;
  end

  // bit_last_next lets the parent register outputs that must coincide with bit_last.
  assign bit_last      = (cnt == CNT_LAST);
  assign bit_last_next = (cnt_n == CNT_LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits,
// with a one-byte holding register so frames can run back to back.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                      i_Clock,
  input  logic                      i_Rst_n,
  input  logic                      i_Tx_DV,
  input  logic [UART_DATA_BITS-1:0] i_Tx_Byte,
  output logic                      o_Tx_Ready,
  output logic                      o_Tx_Active,
  output logic                      o_Tx_Serial,
  output logic                      o_Tx_Done
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t                 state, state_n;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_n;
  logic [UART_DATA_BITS-1:0] hold_byte, hold_n;
  logic [UART_DATA_BITS-1:0] load_byte;
  logic [2:0]                bit_idx, bit_idx_n;
  logic                      stop_idx, stop_idx_n;
  logic                      parity_reg, parity_n;
  logic                      hold_valid, hold_valid_n;
  logic                      serial_n, active_n, done_n;
  logic                      xfer, load_now;
  logic                      bit_last, bit_last_next;

  uart_tx_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_Clock       (i_Clock),
    .i_Rst_n       (i_Rst_n),
    .restart       (state == TX_IDLE),
    .bit_last      (bit_last),
    .bit_last_next (bit_last_next)
  );

  assign xfer       = i_Tx_DV && !hold_valid;
  assign o_Tx_Ready = ~hold_valid;

  always_comb begin
    state_n      = state;
    shift_n      = shift_reg;
    bit_idx_n    = bit_idx;
    stop_idx_n   = stop_idx;
    parity_n     = parity_reg;
    hold_n       = hold_byte;
    hold_valid_n = hold_valid;
    load_byte    = i_Tx_Byte;
    load_now     = 1'b0;

    if (state != TX_IDLE && xfer) begin
      hold_n       = i_Tx_Byte;
      hold_valid_n = 1'b1;
    end

    unique case (state)
      TX_IDLE:      load_now = xfer;
      TX_START_BIT: if (bit_last) begin
        state_n   = TX_DATA_BITS;
        bit_idx_n = '0;
      end
      TX_DATA_BITS: if (bit_last) begin
        shift_n = shift_reg >> 1;
        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
          state_n    = (PARITY_EN != 0) ? TX_PARITY_BIT : TX_STOP_BITS;
          stop_idx_n = 1'b0;
        end else begin
          bit_idx_n = bit_idx + 3'd1;
        end
      end
      TX_PARITY_BIT: if (bit_last) begin
        state_n    = TX_STOP_BITS;
        stop_idx_n = 1'b0;
      end
      TX_STOP_BITS: if (bit_last) begin
        // End of frame: a queued or simultaneously offered byte starts with no idle gap.
        if (stop_idx == STOP_LAST) begin
          if (hold_valid) begin
            load_now     = 1'b1;
            load_byte    = hold_byte;
            hold_valid_n = 1'b0;
          end else if (xfer) begin
            load_now     = 1'b1;
            hold_valid_n = 1'b0;
          end else begin
            state_n = TX_IDLE;
          end
        end else begin
          stop_idx_n = 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase

    if (load_now) begin
      state_n  = TX_START_BIT;
      shift_n  = load_byte;
      parity_n = tx_parity(load_byte, PARITY_ODD != 0);
    end

    case (state_n)
      TX_START_BIT:  serial_n = 1'b0;
      TX_DATA_BITS:  serial_n = shift_n[0];
      TX_PARITY_BIT: serial_n = parity_n;
      default:       serial_n = 1'b1;
    endcase
    active_n = (state_n != TX_IDLE);
    done_n   = bit_last_next && (state_n == TX_STOP_BITS) && (stop_idx_n == STOP_LAST);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= TX_IDLE;
      shift_reg   <= '0;
      hold_byte   <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      parity_reg  <= 1'b0;
      hold_valid  <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state       <= state_n;
      shift_reg   <= shift_n;
      hold_byte   <= hold_n;
      bit_idx     <= bit_idx_n;
      stop_idx    <= stop_idx_n;
      parity_reg  <= parity_n;
      hold_valid  <= hold_valid_n;
      o_Tx_Serial <= serial_n;
      o_Tx_Active <= active_n;
      o_Tx_Done   <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four configurations share one stimulus stream and are
// checked every cycle against a frame-level model, plus literal frame expectations.
module tb_uart_transmitter;

  localparam int NI = 4;
  localparam int P_N    [NI] = '{87, 87, 87, 2};
  localparam int P_PAR  [NI] = '{0, 1, 1, 0};
  localparam int P_ODD  [NI] = '{0, 0, 1, 0};
  localparam int P_STOP [NI] = '{1, 2, 2, 1};
  localparam int RN = P_N[3];
  localparam int CAP = 1100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic [NI-1:0] ser, act, done, rdy;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_transmitter #(
      .CLKS_PER_BIT(P_N[g]),
      .PARITY_EN   (P_PAR[g]),
      .PARITY_ODD  (P_ODD[g]),
      .STOP_BITS   (P_STOP[g])
    ) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Tx_DV     (tx_dv),
      .i_Tx_Byte   (tx_byte),
      .o_Tx_Ready  (rdy[g]),
      .o_Tx_Active (act[g]),
      .o_Tx_Serial (ser[g]),
      .o_Tx_Done   (done[g])
    );
  end

  task automatic checkOutput(input string nm, input int idx, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", nm, idx, got, want, $time);
    end
  endtask

  task automatic checkCount(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic int flen(input int i);
    return (9 + P_PAR[i] + P_STOP[i]) * P_N[i];
  endfunction

  // Value of line bit k (0 = start) for byte b in configuration i.
  function automatic logic line_bit(input logic [7:0] b, input int k, input int i);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (P_PAR[i] != 0 && k == 9) return (^b) ^ (P_ODD[i] != 0);
    return 1'b1;
  endfunction

  // Frame-level model: current byte, cycle position within frame, holding slot.
  int         m_pos  [NI];
  bit         m_busy [NI];
  bit         m_hv   [NI];
  logic [7:0] m_cur  [NI];
  logic [7:0] m_hold [NI];
  logic [7:0] exp_q  [$];
  bit         m_xfer, m_load;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_busy[i] = 1'b0;
        m_pos[i]  = 0;
        m_hv[i]   = 1'b0;
      end
      exp_q.delete();
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_xfer = tx_dv && !m_hv[i];
        m_load = 1'b0;
        if (!m_busy[i]) begin
          m_load = m_xfer;
        end else if (m_pos[i] == flen(i) - 1) begin
          if (m_hv[i]) begin
            m_cur[i] = m_hold[i];
            m_hv[i]  = 1'b0;
            m_pos[i] = 0;
            if (i == 3) exp_q.push_back(m_hold[i]);
          end else if (m_xfer) begin
            m_load = 1'b1;
          end else begin
            m_busy[i] = 1'b0;
          end
        end else begin
          m_pos[i]++;
          if (m_xfer) begin
            m_hold[i] = tx_byte;
            m_hv[i]   = 1'b1;
          end
        end
        if (m_load) begin
          m_busy[i] = 1'b1;
          m_pos[i]  = 0;
          m_cur[i]  = tx_byte;
          if (i == 3) exp_q.push_back(tx_byte);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      checkOutput("serial", i, ser[i], m_busy[i] ? line_bit(m_cur[i], m_pos[i] / P_N[i], i) : 1'b1);
      checkOutput("active", i, act[i], m_busy[i]);
      checkOutput("done", i, done[i], m_busy[i] && (m_pos[i] == flen(i) - 1));
      checkOutput("ready", i, rdy[i], !m_hv[i]);
    end
  end

  // Mid-bit sampling receiver on the fast instance's line.
  int         rx_t = 0;
  int         rx_k = 0;
  int         rx_count = 0;
  bit         rx_busy = 1'b0;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (ser[3] == 1'b0) begin
        rx_busy = 1'b1;
        rx_t    = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % RN == RN / 2) begin
        rx_k = rx_t / RN;
        if (rx_k >= 1 && rx_k <= 8) begin
          rx_sh[rx_k-1] = ser[3];
        end else if (rx_k == 9) begin
          checkOutput("rx_stop", 3, ser[3], 1'b1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL rx_byte inst3: got %0h, expected no frame (t=%0t)", rx_sh, $time);
          end else begin
            checkOutput("rx_byte", 3, rx_sh, exp_q.pop_front());
          end
          rx_count++;
          rx_busy = 1'b0;
        end
      end
    end
  end

  bit cap_ser  [NI][CAP];
  bit cap_done [NI][CAP];
  bit cap_act  [NI][CAP];

  task automatic capture(input int n);
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < NI; i++) begin
        cap_ser[i][t]  = ser[i];
        cap_done[i][t] = done[i];
        cap_act[i][t]  = act[i];
      end
      @(negedge clk);
    end
  endtask

  // Called on a negedge; returns on the negedge right after the transfer edge.
  task automatic applyStimulus(input logic [7:0] b);
    tx_byte = b;
    tx_dv   = 1'b1;
    @(negedge clk);
    tx_dv   = 1'b0;
  endtask

  task automatic check_frame(input string nm, input int i, input logic [11:0] pat, input int nbits);
    for (int k = 0; k < nbits; k++)
      checkOutput(nm, i, cap_ser[i][k*P_N[i] + P_N[i]/2], pat[k]);
  endtask

  int rx_before;
  int guard;

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("reset_serial", 0, ser[0], 1'b1);
    checkOutput("reset_active", 0, act[0], 1'b0);
    checkOutput("reset_done", 0, done[0], 1'b0);
    checkOutput("reset_ready", 0, rdy[0], 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] 8N1 0xA5");
    applyStimulus(8'hA5);
    capture(CAP);
    check_frame("a5_bits", 0, 12'h34A, 10);
    checkOutput("a5_ready_start", 0, cap_act[0][0], 1'b1);
    checkOutput("a5_done_868", 0, cap_done[0][868], 1'b0);
    checkOutput("a5_done_869", 0, cap_done[0][869], 1'b1);
    checkOutput("a5_active_869", 0, cap_act[0][869], 1'b1);
    checkOutput("a5_active_870", 0, cap_act[0][870], 1'b0);
    check_frame("a5_fast_bits", 3, 12'h34A, 10);
    checkOutput("a5_fast_done", 3, cap_done[3][19], 1'b1);

    $display("[TB] parity, 2 stop, 0x07");
    applyStimulus(8'h07);
    capture(CAP);
    check_frame("p_even_bits", 1, 12'hE0E, 12);
    check_frame("p_odd_bits", 2, 12'hC0E, 12);
    checkOutput("p_done_1043", 1, cap_done[1][1043], 1'b1);
    checkOutput("p_done_1042", 1, cap_done[1][1042], 1'b0);
    checkOutput("p_active_1044", 1, cap_act[1][1044], 1'b0);
    checkOutput("p_odd_done_1043", 2, cap_done[2][1043], 1'b1);

    $display("[TB] CLKS_PER_BIT=2, 0x5A");
    applyStimulus(8'h5A);
    capture(CAP);
    for (int t = 0; t < 20; t++) begin
      logic [9:0] pat5a;
      pat5a = 10'h2B4;
      checkOutput("fast_5a_cycle", 3, cap_ser[3][t], pat5a[t/2]);
    end
    checkOutput("fast_done_18", 3, cap_done[3][18], 1'b0);
    checkOutput("fast_done_19", 3, cap_done[3][19], 1'b1);
    checkOutput("fast_active_20", 3, cap_act[3][20], 1'b0);

    $display("[TB] back-to-back 0x00, 0xFF");
    tx_byte = 8'h00;
    tx_dv   = 1'b1;
    @(negedge clk);
    tx_byte = 8'hFF;
    @(negedge clk);
    checkOutput("hold_ready_low", 0, rdy[0], 1'b0);
    tx_byte = 8'h33;
    repeat (200) @(negedge clk);
    checkOutput("third_ignored", 0, rdy[0], 1'b0);
    tx_dv = 1'b0;
    repeat (668) @(negedge clk);
    checkOutput("b2b_done", 0, done[0], 1'b1);
    checkOutput("b2b_last_stop", 0, ser[0], 1'b1);
    @(negedge clk);
    checkOutput("b2b_start", 0, ser[0], 1'b0);
    checkOutput("b2b_active", 0, act[0], 1'b1);
    checkOutput("b2b_ready", 0, rdy[0], 1'b1);
    repeat (130) @(negedge clk);
    checkOutput("b2b_ff_bit0", 0, ser[0], 1'b1);
    repeat (745) @(negedge clk);
    checkOutput("no_third_frame", 0, act[0], 1'b0);
    repeat (800) @(negedge clk);

    $display("[TB] reset during data bit 3 of 0x3C");
    applyStimulus(8'h3C);
    repeat (390) @(negedge clk);
    checkOutput("pre_reset_active", 0, act[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_serial", 0, ser[0], 1'b1);
    checkOutput("midrst_active", 0, act[0], 1'b0);
    checkOutput("midrst_ready", 0, rdy[0], 1'b1);
    checkOutput("midrst_done", 0, done[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h81);
    capture(CAP);
    check_frame("after_rst_bits", 0, 12'h302, 10);
    checkOutput("after_rst_done", 0, cap_done[0][869], 1'b1);

    $display("[TB] loopback 0x00..0xFF");
    rx_before = rx_count;
    for (int b = 0; b < 256; b++) begin
      tx_byte = 8'(b);
      tx_dv   = 1'b1;
      guard   = 0;
      while (m_hv[3] && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) begin
        total++;
        bad++;
        $display("[TB] FAIL loopback_timeout: byte %0d not accepted within 100 cycles", b);
        break;
      end
      @(negedge clk);
    end
    tx_dv = 1'b0;
    repeat (2500) @(negedge clk);
    checkCount("loopback_rx_count", rx_count - rx_before, 256);
    checkCount("loopback_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
